// File: rtl/wm_pkg.sv
// Shared definitions for the wash-machine coin acceptor: the acceptor state
// enumeration and the default parameter values used by every file of the block.
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int CREDIT_W            = 4;
  localparam int DEF_PRICE           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_REFUND_ON       = 3;
  localparam int DEF_MAX_CREDIT      = 15;

endpackage

// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin acceptor and its environment (coin sensor,
// user panel, wash controller, reject gate and return solenoid).
interface coin_acceptor_if;
  import wm_pkg::*;

  // Handshake: consume is a one-cycle strobe from the wash controller, acted on
  // only while coin is high; coin_reject is a one-cycle strobe to the reject
  // gate; cancel is a synchronous level sampled on every rising clock edge.
  logic                coin_in;
  logic                cancel;
  logic                consume;
  logic                coin;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                refund_pulse;
  logic                refund_busy;
  state_t              state_dbg;

  modport master (
    output coin_in, cancel, consume,
    input  coin, credit, coin_reject, refund_pulse, refund_busy, state_dbg
  );

  modport slave (
    input  coin_in, cancel, consume,
    output coin, credit, coin_reject, refund_pulse, refund_busy, state_dbg
  );

endinterface

// File: rtl/coin_debouncer.sv
// Two-flop synchronizer plus debounce for the raw coin sensor. Emits a
// single-cycle accept once per sufficiently long high level.
module coin_debouncer #(
  parameter int DEBOUNCE_CYCLES = wm_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic coin_in,
  output logic accept
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          armed;
  logic [CW-1:0] cnt;

  // armed: waiting for a long high; otherwise waiting for a long low to re-arm.
  // The counter only advances while sync2 shows the level currently awaited.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      armed  <= 1'b1;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      sync1  <= coin_in;
      sync2  <= sync1;
      accept <= 1'b0;
      if (sync2 == armed) begin
        if (cnt == LAST) begin
          cnt    <= '0;
          armed  <= ~armed;
          accept <= armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: counts debounced coins into a saturating credit, signals
// payment to the wash controller and pays change/cancelled credit back in pulses.
module coin_acceptor
  import wm_pkg::*;
#(
  parameter int PRICE           = DEF_PRICE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REFUND_ON       = DEF_REFUND_ON,
  parameter int MAX_CREDIT      = DEF_MAX_CREDIT
) (
  input logic            clock,
  input logic            reset,
  coin_acceptor_if.slave bus
);

  localparam int                  RW      = $clog2(REFUND_ON + 1);
  localparam logic [RW-1:0]       R_LAST  = RW'(REFUND_ON - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n, credit_after;
  logic                phase_hi_q, phase_hi_n;
  logic [RW-1:0]       rcnt_q, rcnt_n;
  logic                reject_q, reject_n;
  logic                accept;
  logic                take;

  coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .coin_in (bus.coin_in),
    .accept  (accept)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      phase_hi_q <= 1'b0;
      rcnt_q     <= '0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      credit_q   <= credit_n;
      phase_hi_q <= phase_hi_n;
      rcnt_q     <= rcnt_n;
      reject_q   <= reject_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    credit_n     = credit_q;
    phase_hi_n   = phase_hi_q;
    rcnt_n       = rcnt_q;
    take         = accept && (state_q != REFUND) && (credit_q < MAX_C);
    reject_n     = accept && !take;
    credit_after = take ? credit_q + 1'b1 : credit_q;

    case (state_q)
      IDLE: begin
        credit_n = credit_after;
        if (credit_after >= PRICE_C)    state_n = PAID;
        else if (credit_after != '0)    state_n = COLLECT;
      end
      COLLECT: begin
        // A coin landing on the cancel edge is already in credit_after, so it is refunded.
        credit_n = credit_after;
        if (bus.cancel) begin
          state_n    = REFUND;
          phase_hi_n = 1'b1;
          rcnt_n     = '0;
        end else if (credit_after >= PRICE_C) begin
          state_n = PAID;
        end
      end
      PAID: begin
        if (bus.consume) begin
          credit_n = credit_after - PRICE_C;
          state_n  = (credit_after == PRICE_C) ? IDLE : REFUND;
        end else begin
          credit_n = credit_after;
          if (bus.cancel) state_n = REFUND;
        end
        phase_hi_n = 1'b1;
        rcnt_n     = '0;
      end
      REFUND: begin
        if (rcnt_q == R_LAST) begin
          rcnt_n = '0;
          if (phase_hi_q) begin
            phase_hi_n = 1'b0;
            if (credit_q != '0) credit_n = credit_q - 1'b1;
          end else if (credit_q == '0) begin
            state_n = IDLE;
          end else begin
            phase_hi_n = 1'b1;
          end
        end else begin
          rcnt_n = rcnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.coin         = (state_q == PAID);
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = reject_q;
  assign bus.refund_pulse = (state_q == REFUND) && phase_hi_q;
  assign bus.refund_busy  = (state_q == REFUND);
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed coin/cancel/consume scenarios, a
// per-cycle behavioural reference and a credit-sequence scoreboard.
module tb_coin_acceptor;
  import wm_pkg::*;

  localparam int PRICE = 4;
  localparam int DEB   = 8;
  localparam int RON   = 3;
  localparam int MAXC  = 15;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_PAID    = 2;
  localparam int M_REFUND  = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic coin_in, cancel, consume;

  always #5 clock = ~clock;

  coin_acceptor_if bus ();
  assign bus.coin_in = coin_in;
  assign bus.cancel  = cancel;
  assign bus.consume = consume;

  coin_acceptor #(
    .PRICE(PRICE), .DEBOUNCE_CYCLES(DEB), .REFUND_ON(RON), .MAX_CREDIT(MAXC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Sensor level reaches the debounce decision two samples late; a coin is
  // credited on the edge after the debounce decision.
  int m_state, m_credit, m_t, hi_run, lo_run;
  bit m_rej, m_acc, m_armed;
  bit samp_q[$];

  function automatic void model_reset();
    m_state  = M_IDLE;
    m_credit = 0;
    m_t      = 0;
    m_rej    = 0;
    m_acc    = 0;
    m_armed  = 1;
    hi_run   = 0;
    lo_run   = 0;
    samp_q   = '{1'b0, 1'b0};
  endfunction

  function automatic void model_step(input bit cin, input bit can, input bit con);
    bit d, acc, take;
    int ca, ph;
    acc = m_acc;
    d = samp_q.pop_front();
    samp_q.push_back(cin);
    if (d) begin hi_run++; lo_run = 0; end
    else   begin lo_run++; hi_run = 0; end
    m_acc = 0;
    if (m_armed && hi_run == DEB) begin m_acc = 1; m_armed = 0; end
    else if (!m_armed && lo_run == DEB) m_armed = 1;

    take  = acc && (m_state != M_REFUND) && (m_credit < MAXC);
    m_rej = acc && !take;
    ca    = m_credit + (take ? 1 : 0);
    case (m_state)
      M_IDLE: begin
        m_credit = ca;
        if (ca >= PRICE) m_state = M_PAID;
        else if (ca > 0) m_state = M_COLLECT;
      end
      M_COLLECT: begin
        m_credit = ca;
        if (can) begin m_state = M_REFUND; m_t = 0; end
        else if (ca >= PRICE) m_state = M_PAID;
      end
      M_PAID: begin
        if (con) begin
          m_credit = ca - PRICE;
          if (m_credit > 0) begin m_state = M_REFUND; m_t = 0; end
          else m_state = M_IDLE;
        end else begin
          m_credit = ca;
          if (can) begin m_state = M_REFUND; m_t = 0; end
        end
      end
      default: begin
        ph = m_t % (2 * RON);
        if (ph == RON - 1 && m_credit > 0) m_credit--;
        if (ph == 2 * RON - 1 && m_credit == 0) m_state = M_IDLE;
        m_t++;
      end
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else       model_step(coin_in, cancel, consume);
  end

  bit cmp_en = 0;
  always @(negedge clock) begin
    if (cmp_en) begin
      check("coin",         bus.coin,         (m_state == M_PAID) ? 1 : 0);
      check("credit",       bus.credit,       m_credit);
      check("coin_reject",  bus.coin_reject,  m_rej ? 1 : 0);
      check("refund_busy",  bus.refund_busy,  (m_state == M_REFUND) ? 1 : 0);
      check("refund_pulse", bus.refund_pulse,
            (m_state == M_REFUND && (m_t % (2 * RON)) < RON) ? 1 : 0);
    end
  end

  // ---------------- scoreboard for credit steps ----------------
  logic [3:0] exp_q[$];
  logic [3:0] last_credit = '0;
  bit         sb_en = 0;

  always @(negedge clock) begin
    if (sb_en && bus.credit != last_credit) begin
      if (exp_q.size() == 0) check("credit_seq_extra", bus.credit, last_credit);
      else                   check("credit_seq", bus.credit, exp_q.pop_front());
    end
    last_credit = bus.credit;
  end

  // ---------------- event monitor ----------------
  int n_pulse, n_pulse_cyc, n_rej, n_coin_hi;
  bit prev_pulse = 0;

  always @(negedge clock) begin
    if (bus.refund_pulse && !prev_pulse) n_pulse++;
    if (bus.refund_pulse) n_pulse_cyc++;
    if (bus.coin_reject)  n_rej++;
    if (bus.coin)         n_coin_hi++;
    prev_pulse = bus.refund_pulse;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_counts();
    n_pulse = 0; n_pulse_cyc = 0; n_rej = 0; n_coin_hi = 0;
  endtask

  task automatic insert_coin(input int hi, input int lo);
    coin_in = 1'b1; tick(hi);
    coin_in = 1'b0; tick(lo);
  endtask

  task automatic wait_refund_done(input int budget);
    int k = 0;
    while (bus.refund_busy && k < budget) begin tick(1); k++; end
    check("refund_done_in_budget", bus.refund_busy, 0);
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses_before;
    coin_in = 0; cancel = 0; consume = 0; reset = 1;
    clear_counts();
    tick(3);
    reset = 0;
    cmp_en = 1;
    tick(2);

    check("rst_credit", bus.credit, 0);
    check("rst_coin", bus.coin, 0);
    check("rst_busy", bus.refund_busy, 0);
    check("rst_pulse", bus.refund_pulse, 0);
    check("rst_state", bus.state_dbg, IDLE);

    // short glitch is ignored
    coin_in = 1; tick(4); coin_in = 0; tick(25);
    check("glitch_credit", bus.credit, 0);
    check("glitch_state", bus.state_dbg, IDLE);

    // four coins, first with latency probe
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    sb_en = 1;
    coin_in = 1; tick(10);
    check("latency_edge9", bus.credit, 0);
    tick(1);
    check("latency_edge10", bus.credit, 1);
    tick(9); coin_in = 0; tick(20);
    check("one_coin_state", bus.state_dbg, COLLECT);
    for (int i = 0; i < 3; i++) insert_coin(20, 20);
    check("four_credit", bus.credit, 4);
    check("four_coin", bus.coin, 1);
    check("credit_seq_drained", exp_q.size(), 0);
    sb_en = 0;

    // credit 6 then consume: change of 2 refunded
    insert_coin(20, 20); insert_coin(20, 20);
    check("six_credit", bus.credit, 6);
    clear_counts();
    consume = 1; tick(1); consume = 0;
    check("consume_credit", bus.credit, 2);
    check("consume_busy", bus.refund_busy, 1);
    check("consume_coin", bus.coin, 0);
    wait_refund_done(100);
    check("change_pulses", n_pulse, 2);
    check("change_pulse_cycles", n_pulse_cyc, 2 * RON);
    check("change_credit", bus.credit, 0);
    check("change_state", bus.state_dbg, IDLE);

    // credit 3, cancel, coin during refund is rejected
    for (int i = 0; i < 3; i++) insert_coin(20, 20);
    check("three_credit", bus.credit, 3);
    clear_counts();
    cancel = 1; tick(1); cancel = 0;
    check("cancel_busy", bus.refund_busy, 1);
    check("cancel_credit", bus.credit, 3);
    coin_in = 1; tick(20); coin_in = 0;
    wait_refund_done(100);
    tick(20);
    check("cancel_pulses", n_pulse, 3);
    check("cancel_rejects", n_rej, 1);
    check("cancel_coin_never", n_coin_hi, 0);
    check("cancel_credit_end", bus.credit, 0);

    // consume and cancel together in PAID with exact price
    for (int i = 0; i < 4; i++) insert_coin(20, 20);
    check("paid_credit", bus.credit, 4);
    clear_counts();
    consume = 1; cancel = 1; tick(1); consume = 0; cancel = 0;
    check("both_state", bus.state_dbg, IDLE);
    check("both_credit", bus.credit, 0);
    check("both_coin", bus.coin, 0);
    tick(10);
    check("both_no_pulse", n_pulse, 0);

    // saturation at MAX_CREDIT
    clear_counts();
    for (int i = 0; i < 15; i++) insert_coin(20, 20);
    check("sat_credit15", bus.credit, 15);
    check("sat_no_reject", n_rej, 0);
    insert_coin(20, 20);
    check("sat_credit16", bus.credit, 15);
    check("sat_reject", n_rej, 1);

    // reset in the middle of a refund pulse
    cancel = 1; tick(1); cancel = 0;
    tick(1);
    check("mid_refund_pulse", bus.refund_pulse, 1);
    #2 reset = 1;
    #1;
    check("arst_pulse", bus.refund_pulse, 0);
    check("arst_busy", bus.refund_busy, 0);
    check("arst_coin", bus.coin, 0);
    check("arst_reject", bus.coin_reject, 0);
    check("arst_credit", bus.credit, 0);
    tick(2);
    reset = 0;
    pulses_before = n_pulse;
    tick(20);
    check("arst_no_more_pulse", n_pulse, pulses_before);
    check("arst_state", bus.state_dbg, IDLE);

    // reset in the middle of a debounce discards the coin
    coin_in = 1; tick(6);
    reset = 1; tick(1); coin_in = 0; tick(1); reset = 0;
    tick(20);
    check("deb_reset_credit", bus.credit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter PRICE, default 4, credits required for one wash cycle.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 8, consecutive synchronized samples needed to accept or re-arm a coin.
REQ-003 SHALL have parameter REFUND_ON, default 3, cycles per refund-pulse high phase and per low gap.
REQ-004 SHALL have parameter MAX_CREDIT, default 15, credit saturation value.
REQ-005 SHALL have port clock, input, 1, single clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port coin_in, input, 1, raw asynchronous coin-sensor level.
REQ-008 SHALL have port cancel, input, 1, user cancel request, synchronous.
REQ-009 SHALL have port consume, input, 1, single-cycle pulse from the wash controller accepting payment.
REQ-010 SHALL have port coin, output, 1, payment-complete level to the wash controller.
REQ-011 SHALL have port credit, output, 4, current credit count.
REQ-012 SHALL have port coin_reject, output, 1, single-cycle pulse that opens the reject gate.
REQ-013 SHALL have port refund_pulse, output, 1, drives the coin-return solenoid.
REQ-014 SHALL have port refund_busy, output, 1, high while in state REFUND.

Function
REQ-015 SHALL pass coin_in through a 2-flop synchronizer before any use.
REQ-016 SHALL generate a coin-accept event on the cycle the synchronized input has been high for DEBOUNCE_CYCLES consecutive samples, once per high level.
REQ-017 SHALL re-arm only after DEBOUNCE_CYCLES consecutive low synchronized samples; highs shorter than DEBOUNCE_CYCLES SHALL be ignored.
REQ-018 SHALL implement states IDLE, COLLECT, PAID and REFUND.
REQ-019 SHALL, on an accept event in IDLE, COLLECT or PAID with credit < MAX_CREDIT, increment credit by 1 on that edge.
REQ-020 SHALL, on an accept event with credit == MAX_CREDIT or in REFUND, leave credit unchanged and pulse coin_reject for one cycle.
REQ-021 SHALL go IDLE->COLLECT when credit becomes nonzero, and IDLE/COLLECT->PAID on the edge credit reaches >= PRICE.
REQ-022 SHALL drive coin = 1 exactly while in PAID.
REQ-023 SHALL, on consume in PAID, subtract PRICE from credit and go to REFUND if the remainder is nonzero, else to IDLE.
REQ-024 SHALL ignore consume outside PAID.
REQ-025 SHALL, on cancel in COLLECT or PAID, go to REFUND holding all credit; cancel in IDLE or REFUND SHALL be ignored.
REQ-026 SHALL give consume priority over a simultaneous cancel in PAID.
REQ-027 SHALL count a coin accepted on the same edge as cancel before entering REFUND, so it is refunded.
REQ-028 SHALL, in REFUND, emit per credit unit refund_pulse high for REFUND_ON cycles then low for REFUND_ON cycles, decrementing credit at the end of each high phase.
REQ-029 SHALL leave REFUND for IDLE at the end of the low gap following the decrement that makes credit 0.
REQ-030 SHALL keep credit arithmetic in 4 bits with no wrap, saturating at MAX_CREDIT and never going below 0.

Reset
REQ-031 SHALL, on reset, asynchronously force state IDLE, credit 0, synchronizer and debounce counters 0, and coin, coin_reject, refund_pulse and refund_busy 0.
REQ-032 SHALL, on reset mid-REFUND or mid-debounce, discard the pending refund or coin without any further output pulse.

Structure
REQ-033 SHALL place the state enumeration and the parameter default constants in shared package wm_pkg.
REQ-034 SHALL implement the synchronizer and debounce as sub-module coin_debouncer, whose output is a single-cycle accept event.

Verification
REQ-035 SHALL test a 4-cycle coin_in glitch: expect no credit change.
REQ-036 SHALL test four 20-cycle coins: expect credit to step 1,2,3,4, each increment 10 cycles after the first sampled high; coin=1 after the 4th.
REQ-037 SHALL test credit 6 then consume: expect credit 2, REFUND entered, two 3-cycle refund pulses, then IDLE with credit 0.
REQ-038 SHALL test credit 3 then cancel: expect three refund pulses and coin staying 0; a coin inserted during REFUND gives one coin_reject pulse.
REQ-039 SHALL test consume and cancel on the same edge in PAID with credit 4: expect IDLE, credit 0, no refund pulse.
REQ-040 SHALL test 16 coins: expect credit to saturate at 15 and the 16th coin to produce coin_reject; reset mid-refund gives all outputs 0 immediately.
